// File: rtl/nasti_dma_pkg.sv
// Shared types for the NASTI DMA descriptor scheduler.
// Descriptor fields are stored at full 64-bit width; the top narrows to ADDR_WIDTH.
package nasti_dma_pkg;

  localparam int DESC_AW = 64;
  localparam int DESC_IW = 8;

  typedef struct packed {
    logic [DESC_AW-1:0] src;
    logic [DESC_AW-1:0] dest;
    logic [DESC_AW-1:0] len;
    logic [7:0]         mask;
    logic [DESC_IW-1:0] id;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  // Mover works on whole 8-byte beats; zero or ragged lengths are rejected.
  function automatic logic len_bad(input logic [DESC_AW-1:0] len);
    return (len == '0) || (len[2:0] != 3'd0);
  endfunction

endpackage

// File: rtl/nasti_dma_desc_fifo.sv
// Descriptor queue: wrap-around pointers plus an occupancy count.
// Head entry is visible on dout while not empty.
module nasti_dma_desc_fifo
  import nasti_dma_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          push,
  input  desc_t         din,
  input  logic          pop,
  output desc_t         dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  desc_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nasti_dma_scheduler.sv
// Round-robin descriptor intake, queueing and data-mover sequencing
// with a one-cycle completion pulse per descriptor.
module nasti_dma_scheduler
  import nasti_dma_pkg::*;
#(
  parameter  int NREQ       = 2,
  parameter  int ADDR_WIDTH = 64,
  parameter  int DEPTH      = 4,
  localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_src,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_dest,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_len,
  input  logic [NREQ*8-1:0]      req_mask,
  output logic [ADDR_WIDTH-1:0]  mv_src_addr,
  output logic [ADDR_WIDTH-1:0]  mv_dest_addr,
  output logic [ADDR_WIDTH-1:0]  mv_length,
  output logic [7:0]             mv_mask,
  output logic                   mv_en,
  input  logic                   mv_done,
  output logic                   cmp_valid,
  output logic [IW-1:0]          cmp_id,
  output logic                   cmp_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] rr;
  logic [IW-1:0] gnt;
  logic          gnt_ok;
  logic          push;
  logic          pop;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  desc_t         din;
  desc_t         head;
  state_t        state;
  state_t        nxt;
  logic          unused_bits;

  function automatic int rr_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Walk downward so the lowest offset from rr wins.
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(int'(rr), k)]) begin
        gnt    = IW'(rr_idx(int'(rr), k));
        gnt_ok = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (aresetn && gnt_ok && !q_full) req_ready[gnt] = 1'b1;
  end

  assign push = |(req_valid & req_ready);

  always_comb begin
    din      = '0;
    din.src  = DESC_AW'(req_src[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH]);
    din.dest = DESC_AW'(req_dest[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH]);
    din.len  = DESC_AW'(req_len[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH]);
    din.mask = req_mask[int'(gnt)*8 +: 8];
    din.id   = DESC_IW'(gnt);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr <= '0;
    end else if (push) begin
      rr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    end
  end

  nasti_dma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .dout    (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign unused_bits = ^{q_count, head};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (!q_empty) nxt = S_CHECK;
      S_CHECK:     nxt = len_bad(DESC_AW'(mv_length)) ? S_COMPLETE : S_START;
      S_START:     nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!mv_done) nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (mv_done) nxt = S_COMPLETE;
      S_COMPLETE:  nxt = S_IDLE;
      default:     nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == S_IDLE) && !q_empty;
    mv_en     = (state == S_START);
    cmp_valid = (state == S_COMPLETE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mv_src_addr  <= '0;
      mv_dest_addr <= '0;
      mv_length    <= '0;
      mv_mask      <= '0;
      cmp_id       <= '0;
      cmp_err      <= 1'b0;
    end else begin
      if (pop) begin
        mv_src_addr  <= ADDR_WIDTH'(head.src);
        mv_dest_addr <= ADDR_WIDTH'(head.dest);
        mv_length    <= ADDR_WIDTH'(head.len);
        mv_mask      <= head.mask;
        cmp_id       <= IW'(head.id);
      end
      if (state == S_CHECK) cmp_err <= len_bad(DESC_AW'(mv_length));
    end
  end

endmodule

// File: tb/tb_nasti_dma_scheduler.sv
// Scoreboard bench for nasti_dma_scheduler: requester queues, a mover
// model, and in-order completion checking.
module tb_nasti_dma_scheduler;

  localparam int NREQ  = 2;
  localparam int AW    = 64;
  localparam int DEPTH = 4;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_src;
  logic [NREQ*AW-1:0]   req_dest;
  logic [NREQ*AW-1:0]   req_len;
  logic [NREQ*8-1:0]    req_mask;
  logic [AW-1:0]        mv_src_addr;
  logic [AW-1:0]        mv_dest_addr;
  logic [AW-1:0]        mv_length;
  logic [7:0]           mv_mask;
  logic                 mv_en;
  logic                 mv_done;
  logic                 cmp_valid;
  logic [0:0]           cmp_id;
  logic                 cmp_err;

  nasti_dma_scheduler #(
    .NREQ       (NREQ),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_dest     (req_dest),
    .req_len      (req_len),
    .req_mask     (req_mask),
    .mv_src_addr  (mv_src_addr),
    .mv_dest_addr (mv_dest_addr),
    .mv_length    (mv_length),
    .mv_mask      (mv_mask),
    .mv_en        (mv_en),
    .mv_done      (mv_done),
    .cmp_valid    (cmp_valid),
    .cmp_id       (cmp_id),
    .cmp_err      (cmp_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] src;
    logic [63:0] dest;
    logic [63:0] len;
    logic [7:0]  mask;
    int          id;
    logic        err;
  } exp_t;

  exp_t pend [NREQ][$];
  exp_t sb[$];
  int   grants[$];
  int   cmps[$];
  int   acc_at_cmp[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   cmp_cnt = 0;
  int   mv_en_cnt = 0;
  int   m_rr = 0;
  int   busy_len = 10;
  int   rise_cyc = -100;
  logic prev_done = 1'b1;
  logic chk_lat = 1'b0;
  logic [NREQ-1:0] acc = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [63:0] src,
                      input logic [63:0] dest, input logic [63:0] len,
                      input logic [7:0] mask);
    exp_t e;
    e.src  = src;
    e.dest = dest;
    e.len  = len;
    e.mask = mask;
    e.id   = i;
    e.err  = (len == 64'd0) || (len[2:0] != 3'd0);
    pend[i].push_back(e);
  endtask

  task automatic wait_cmps(input int n, input int budget);
    for (int k = 0; k < budget && cmp_cnt < n; k++) @(posedge aclk);
    check("cmp_count", 64'(cmp_cnt), 64'(n));
  endtask

  task automatic wait_mv_en(input int n, input int budget);
    for (int k = 0; k < budget && mv_en_cnt < n; k++) @(posedge aclk);
    check("mv_en_seen", 64'(mv_en_cnt), 64'(n));
  endtask

  always @(posedge aclk) cyc++;

  // Monitor: sample between edges, push accepts, pop on completion.
  always @(negedge aclk) begin
    int g;
    int pg;
    exp_t e;
    acc = req_valid & req_ready;
    if (!aresetn) begin
      sb.delete();
      m_rr = 0;
    end else begin
      if (acc != '0) begin
        check("ready_onehot", 64'($countones(acc)), 64'd1);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (acc[i]) g = i;
        pg = -1;
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % NREQ]) pg = (m_rr + k) % NREQ;
        check("grant", 64'(g), 64'(pg));
        m_rr = (g + 1) % NREQ;
        sb.push_back(pend[g][0]);
        grants.push_back(g);
        acc_at_cmp.push_back(cmp_cnt);
        acc_cnt++;
      end
      if (mv_en) begin
        mv_en_cnt++;
        if (sb.size() == 0) begin
          check("mv_en_unexpected", 64'd1, 64'd0);
        end else begin
          check("mv_src", mv_src_addr, sb[0].src);
          check("mv_dest", mv_dest_addr, sb[0].dest);
          check("mv_len", mv_length, sb[0].len);
          check("mv_mask", 64'(mv_mask), 64'(sb[0].mask));
          check("mv_en_on_bad", 64'(sb[0].err), 64'd0);
        end
      end
      if (mv_done && !prev_done) rise_cyc = cyc;
      if (cmp_valid) begin
        cmp_cnt++;
        cmps.push_back(int'(cmp_id));
        if (sb.size() == 0) begin
          check("cmp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("cmp_id", 64'(cmp_id), 64'(e.id));
          check("cmp_err", 64'(cmp_err), 64'(e.err));
          if (chk_lat && !e.err)
            check("done_to_cmp", 64'(cyc - rise_cyc), 64'd1);
        end
      end
    end
    prev_done = mv_done;
  end

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    int c0;
    int g0;
    int a0;
    int m0;
    req_valid = '1;
    req_src   = '1;
    req_dest  = '1;
    req_len   = '1;
    req_mask  = '1;
    mv_done   = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mv_en", 64'(mv_en), 64'd0);
    check("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    check("rst_cmp_err", 64'(cmp_err), 64'd0);
    check("rst_cmp_id", 64'(cmp_id), 64'd0);
    check("rst_mv_src", mv_src_addr, 64'd0);
    check("rst_mv_dest", mv_dest_addr, 64'd0);
    check("rst_mv_len", mv_length, 64'd0);
    check("rst_mv_mask", 64'(mv_mask), 64'd0);
    req_valid = '0;
    req_src   = '0;
    req_dest  = '0;
    req_len   = '0;
    req_mask  = '0;
    aresetn   = 1'b1;

    fork
      // Requester driver: retire accepted heads, present next ones.
      forever begin
        @(posedge aclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
          if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
          if (pend[i].size() > 0) begin
            req_valid[i]          = 1'b1;
            req_src[i*AW +: AW]   = pend[i][0].src;
            req_dest[i*AW +: AW]  = pend[i][0].dest;
            req_len[i*AW +: AW]   = pend[i][0].len;
            req_mask[i*8 +: 8]    = pend[i][0].mask;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      // Mover model: drop done for busy_len cycles after each mv_en.
      begin
        int seen;
        int cnt;
        seen = 0;
        cnt  = 0;
        forever begin
          @(posedge aclk);
          #1;
          if (!aresetn) begin
            mv_done = 1'b1;
            cnt     = 0;
            seen    = mv_en_cnt;
          end else if (seen != mv_en_cnt) begin
            seen    = mv_en_cnt;
            mv_done = 1'b0;
            cnt     = busy_len;
          end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) mv_done = 1'b1;
          end
        end
      end
    join_none

    // Single good descriptor, completion latency after done rises.
    busy_len = 10;
    chk_lat  = 1'b1;
    push(0, 64'h1000, 64'h2000, 64'h40, 8'hFF);
    wait_cmps(1, 200);
    check("t1_mv_en_count", 64'(mv_en_cnt), 64'd1);
    check("t1_cmp_id", 64'(cmps[0]), 64'd0);
    chk_lat = 1'b0;

    // Both requesters streaming: grants and completions alternate.
    do_reset();
    busy_len = 2;
    g0 = grants.size();
    c0 = cmp_cnt;
    for (int k = 0; k < 3; k++) begin
      push(0, 64'h10000 + 64'(k) * 64'h100, 64'h20000, 64'h80, 8'hF0);
      push(1, 64'h30000 + 64'(k) * 64'h100, 64'h40000, 64'h18, 8'h0F);
    end
    wait_cmps(c0 + 6, 400);
    for (int k = 0; k < 6; k++) begin
      if (grants.size() > g0 + k)
        check("t2_grant_order", 64'(grants[g0 + k]), 64'(k % 2));
      if (cmps.size() > c0 + k)
        check("t2_cmp_order", 64'(cmps[c0 + k]), 64'(k % 2));
    end

    // Stalled mover: queue holds DEPTH, next request waits for a pop.
    busy_len = 60;
    a0 = acc_cnt;
    c0 = cmp_cnt;
    m0 = mv_en_cnt;
    push(0, 64'h5000, 64'h6000, 64'h100, 8'hAA);
    wait_mv_en(m0 + 1, 50);
    for (int k = 0; k < 5; k++)
      push(0, 64'h7000 + 64'(k) * 64'h40, 64'h8000, 64'h40, 8'h55);
    repeat (20) @(posedge aclk);
    @(negedge aclk);
    check("t3_accepts_full", 64'(acc_cnt - a0), 64'(1 + DEPTH));
    check("t3_valid_held", 64'(req_valid[0]), 64'd1);
    check("t3_ready_full", 64'(req_ready[0]), 64'd0);
    wait_cmps(c0 + 6, 1000);
    if (acc_at_cmp.size() > a0 + 5)
      check("t3_fifth_after_pop", 64'(acc_at_cmp[a0 + 5] > c0), 64'd1);
    else
      check("t3_fifth_accepted", 64'(acc_at_cmp.size()), 64'(a0 + 6));

    // Bad lengths complete with error and never start the mover.
    busy_len = 5;
    c0 = cmp_cnt;
    m0 = mv_en_cnt;
    push(1, 64'h3000, 64'h4000, 64'h0, 8'h0F);
    push(1, 64'h3100, 64'h4100, 64'h44, 8'h0F);
    wait_cmps(c0 + 2, 100);
    check("t4_no_mv_en", 64'(mv_en_cnt), 64'(m0));

    // Reset in WAIT_DONE with two descriptors queued.
    busy_len = 50;
    m0 = mv_en_cnt;
    a0 = acc_cnt;
    for (int k = 0; k < 3; k++)
      push(0, 64'h9000 + 64'(k) * 64'h80, 64'hA000, 64'h80, 8'hCC);
    wait_mv_en(m0 + 1, 50);
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    check("t5_queued", 64'(acc_cnt - a0), 64'd3);
    aresetn = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    #1;
    check("t5_rst_mv_en", 64'(mv_en), 64'd0);
    check("t5_rst_cmp_valid", 64'(cmp_valid), 64'd0);
    check("t5_rst_mv_src", mv_src_addr, 64'd0);
    check("t5_rst_mv_len", mv_length, 64'd0);
    check("t5_rst_cmp_id", 64'(cmp_id), 64'd0);
    check("t5_rst_ready", 64'(req_ready), 64'd0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    c0 = cmp_cnt;
    m0 = mv_en_cnt;
    repeat (80) @(posedge aclk);
    check("t5_no_cmp", 64'(cmp_cnt), 64'(c0));
    check("t5_queue_empty", 64'(mv_en_cnt), 64'(m0));

    busy_len = 3;
    push(1, 64'hB000, 64'hC000, 64'h8, 8'h01);
    wait_cmps(c0 + 1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
